// File: rtl/mat_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mat_mem_arbiter_pkg
// Shared definitions for the matrix-RAM session arbiter: port count, port ids,
// FSM state encoding and small port-id helper functions.
// -----------------------------------------------------------------------------
package mat_mem_arbiter_pkg;

    localparam int NPORT = 3;

    typedef logic [1:0] port_id_t;

    localparam port_id_t PORT_LOAD   = 2'd0;
    localparam port_id_t PORT_ELIM   = 2'd1;
    localparam port_id_t PORT_UNLOAD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN  = 2'b01,
        ST_GAP  = 2'b10
    } arb_state_t;

    // Next port in round-robin order (wraps 2 -> 0).
    function automatic port_id_t next_port(input port_id_t p);
        port_id_t n;
        case (p)
            PORT_LOAD: n = PORT_ELIM;
            PORT_ELIM: n = PORT_UNLOAD;
            default:   n = PORT_LOAD;
        endcase
        return n;
    endfunction

    // One-hot vector for a port id; an illegal id maps to no port.
    function automatic logic [NPORT-1:0] port_onehot(input port_id_t p);
        logic [NPORT-1:0] oh;
        case (p)
            PORT_LOAD:   oh = 3'b001;
            PORT_ELIM:   oh = 3'b010;
            PORT_UNLOAD: oh = 3'b100;
            default:     oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mat_mem_arbiter_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// mat_mem_arbiter_rd_tag_pipe
// DEPTH-deep shift register of {valid, port id}, aligned with the RAM read
// latency so each read return can be routed to the port that issued it.
//   clk, rst   : clock, synchronous active-high reset (clears all entries)
//   in_valid   : a read is being issued this cycle
//   in_id      : issuing port
//   out_valid  : read data on the RAM output belongs to out_id this cycle
//   out_id     : port owning the returning read data
// -----------------------------------------------------------------------------
module mat_mem_arbiter_rd_tag_pipe
    import mat_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    input  port_id_t in_id,
    output logic     out_valid,
    output port_id_t out_id
);

    logic [DEPTH-1:0] valid_r;
    port_id_t         id_r [DEPTH];

    // Shift stage: a new entry enters every cycle, regardless of arbiter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_r[i] <= PORT_LOAD;
            end
        end else begin
            valid_r[0] <= in_valid;
            id_r[0]    <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                id_r[i]    <= id_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_id    = id_r[DEPTH-1];

endmodule

// File: rtl/mat_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mat_mem_arbiter
// Session-based arbiter for the single-port matrix RAM shared by the loader
// (port 0), the Gauss-elimination controller (port 1) and the unloader
// (port 2). A granted port owns the RAM until it drops req; its address,
// write enable and write data reach the RAM combinationally so cycle-exact
// access sequences are preserved. Read returns are tagged with the issuing
// port.
//   clk, rst           : clock, synchronous active-high reset
//   req[2:0]           : per-port session request
//   gnt[2:0]           : registered one-hot grant
//   req_addr/rw/wdata  : per-port RAM access, port i at slice i
//   mem_addr/rw/wdata  : RAM access of the current owner (zero otherwise)
//   mem_rdata, rdata   : RAM read data, passed through to all requesters
//   rvalid[2:0]        : one-hot owner of rdata this cycle
//   busy               : some port holds a grant
// -----------------------------------------------------------------------------
module mat_mem_arbiter
    import mat_mem_arbiter_pkg::*;
#(
    parameter  int k          = 4,
    parameter  int l          = 4,
    parameter  int READ_DELAY = 2,
    localparam int AW         = (k > 1) ? $clog2(k) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    req,
    output logic [NPORT-1:0]    gnt,
    input  logic [NPORT*AW-1:0] req_addr,
    input  logic [NPORT-1:0]    req_rw,
    input  logic [NPORT*l-1:0]  req_wdata,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_rw,
    output logic [l-1:0]        mem_wdata,
    input  logic [l-1:0]        mem_rdata,
    output logic [l-1:0]        rdata,
    output logic [NPORT-1:0]    rvalid,
    output logic                busy
);

    arb_state_t       state_r, state_nx_s;
    port_id_t         owner_r, owner_nx_s;
    port_id_t         last_owner_r, last_owner_nx_s;
    logic [NPORT-1:0] gnt_r, gnt_nx_s;

    port_id_t         rr_start_s, rr_mid_s, rr_end_s, rr_win_s;
    logic             rr_any_s;

    logic             owner_req_s, owner_rw_s;
    logic [AW-1:0]    owner_addr_s;
    logic [l-1:0]     owner_wdata_s;

    logic             rd_push_s;
    logic             tail_valid_s;
    port_id_t         tail_id_s;

    // Round-robin pick: search starts at the port after the last owner.
    always_comb begin
        rr_start_s = next_port(last_owner_r);
        rr_mid_s   = next_port(rr_start_s);
        rr_end_s   = next_port(rr_mid_s);
        rr_any_s   = |req;
        rr_win_s   = rr_start_s;
        if (req[rr_start_s]) begin
            rr_win_s = rr_start_s;
        end else if (req[rr_mid_s]) begin
            rr_win_s = rr_mid_s;
        end else if (req[rr_end_s]) begin
            rr_win_s = rr_end_s;
        end else begin
            rr_win_s = rr_start_s;
        end
    end

    // Select the current owner's request signals from the packed port buses.
    always_comb begin
        owner_req_s   = 1'b0;
        owner_rw_s    = 1'b0;
        owner_addr_s  = '0;
        owner_wdata_s = '0;
        case (owner_r)
            PORT_LOAD: begin
                owner_req_s   = req[0];
                owner_rw_s    = req_rw[0];
                owner_addr_s  = req_addr[AW-1:0];
                owner_wdata_s = req_wdata[l-1:0];
            end
            PORT_ELIM: begin
                owner_req_s   = req[1];
                owner_rw_s    = req_rw[1];
                owner_addr_s  = req_addr[2*AW-1:AW];
                owner_wdata_s = req_wdata[2*l-1:l];
            end
            PORT_UNLOAD: begin
                owner_req_s   = req[2];
                owner_rw_s    = req_rw[2];
                owner_addr_s  = req_addr[3*AW-1:2*AW];
                owner_wdata_s = req_wdata[3*l-1:2*l];
            end
            default: begin
                owner_req_s   = 1'b0;
                owner_rw_s    = 1'b0;
                owner_addr_s  = '0;
                owner_wdata_s = '0;
            end
        endcase
    end

    // Session FSM next state: grant in IDLE, release in OWN, one dead cycle in GAP.
    always_comb begin
        state_nx_s      = state_r;
        owner_nx_s      = owner_r;
        last_owner_nx_s = last_owner_r;
        gnt_nx_s        = gnt_r;
        case (state_r)
            ST_IDLE: begin
                if (rr_any_s) begin
                    owner_nx_s = rr_win_s;
                    gnt_nx_s   = port_onehot(rr_win_s);
                    state_nx_s = ST_OWN;
                end else begin
                    gnt_nx_s   = 3'b000;
                end
            end
            ST_OWN: begin
                if (!owner_req_s) begin
                    gnt_nx_s        = 3'b000;
                    last_owner_nx_s = owner_r;
                    state_nx_s      = ST_GAP;
                end else begin
                    gnt_nx_s        = port_onehot(owner_r);
                end
            end
            ST_GAP: begin
                gnt_nx_s   = 3'b000;
                state_nx_s = ST_IDLE;
            end
            default: begin
                gnt_nx_s   = 3'b000;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Session FSM state, owner and grant registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= PORT_LOAD;
            last_owner_r <= PORT_UNLOAD;
            gnt_r        <= 3'b000;
        end else begin
            state_r      <= state_nx_s;
            owner_r      <= owner_nx_s;
            last_owner_r <= last_owner_nx_s;
            gnt_r        <= gnt_nx_s;
        end
    end

    // RAM port mux: only a live session reaches the RAM; a write also needs req.
    always_comb begin
        mem_addr  = '0;
        mem_rw    = 1'b0;
        mem_wdata = '0;
        if (state_r == ST_OWN) begin
            mem_addr  = owner_addr_s;
            mem_rw    = owner_req_s & owner_rw_s;
            mem_wdata = owner_wdata_s;
        end else begin
            mem_addr  = '0;
            mem_rw    = 1'b0;
            mem_wdata = '0;
        end
    end

    assign rd_push_s = (state_r == ST_OWN) & owner_req_s & ~owner_rw_s;

    mat_mem_arbiter_rd_tag_pipe #(
        .DEPTH (READ_DELAY)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_push_s),
        .in_id     (owner_r),
        .out_valid (tail_valid_s),
        .out_id    (tail_id_s)
    );

    // Route the returning read to its issuing port by the tag at the pipe tail.
    always_comb begin
        rvalid = 3'b000;
        if (tail_valid_s) begin
            rvalid = port_onehot(tail_id_s);
        end else begin
            rvalid = 3'b000;
        end
    end

    assign gnt   = gnt_r;
    assign busy  = |gnt_r;
    assign rdata = mem_rdata;

endmodule

// File: tb/tb_mat_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mat_mem_arbiter
// Directed bench for mat_mem_arbiter (k=4, l=4, READ_DELAY=2) with a small
// behavioural RAM of matching read latency attached to the mem_* port.
// Inputs change 1 time unit after each rising edge; outputs are checked 1
// time unit later, still well away from the next edge.
// -----------------------------------------------------------------------------
module tb_mat_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, req_rw, gnt, rvalid;
    logic [5:0]  req_addr;
    logic [11:0] req_wdata;
    logic [1:0]  mem_addr;
    logic        mem_rw;
    logic [3:0]  mem_wdata, mem_rdata, rdata;
    logic        busy;

    logic [1:0]  a_v [3];
    logic [3:0]  w_v [3];
    logic [3:0]  ram [4];
    logic [3:0]  rd_p0, rd_p1;

    int total = 0;
    int bad   = 0;

    assign req_addr  = {a_v[2], a_v[1], a_v[0]};
    assign req_wdata = {w_v[2], w_v[1], w_v[0]};

    always #5 clk = ~clk;

    // RAM model: write on the edge, read data appears two cycles after the address.
    always @(posedge clk) begin
        if (mem_rw) ram[mem_addr] <= mem_wdata;
        rd_p0 <= ram[mem_addr];
        rd_p1 <= rd_p0;
    end
    assign mem_rdata = rd_p1;

    mat_mem_arbiter #(
        .k          (4),
        .l          (4),
        .READ_DELAY (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_wdata (req_wdata),
        .mem_addr  (mem_addr),
        .mem_rw    (mem_rw),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] oh;
        rst = 1'b1; req = 3'b000; req_rw = 3'b000;
        for (int i = 0; i < 3; i++) begin a_v[i] = 2'd0; w_v[i] = 4'h0; end
        tick(); tick();
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_rw", mem_rw, 1'b0);
        chk("rst_mem_addr", mem_addr, 2'd0);
        chk("rst_mem_wdata", mem_wdata, 4'h0);
        chk("rst_rvalid", rvalid, 3'b000);

        // Ports 0 and 1 request together; port 0 wins first.
        rst = 1'b0; req = 3'b011; a_v[1] = 2'd3; w_v[1] = 4'hF; #1;
        chk("idle_gnt", gnt, 3'b000);
        chk("idle_mem_rw", mem_rw, 1'b0);
        tick();
        req_rw = 3'b001; a_v[0] = 2'd0; w_v[0] = 4'h5; #1;
        chk("g0_gnt", gnt, 3'b001);
        chk("g0_busy", busy, 1'b1);
        chk("g0_mem_rw", mem_rw, 1'b1);
        chk("g0_mem_addr", mem_addr, 2'd0);
        chk("g0_mem_wdata", mem_wdata, 4'h5);
        tick(); a_v[0] = 2'd1; w_v[0] = 4'hA; #1;
        chk("g1_mem_addr", mem_addr, 2'd1);
        chk("g1_mem_wdata", mem_wdata, 4'hA);
        tick(); a_v[0] = 2'd2; w_v[0] = 4'h3; #1;
        tick(); a_v[0] = 2'd3; w_v[0] = 4'hC; #1;
        chk("g3_mem_addr", mem_addr, 2'd3);
        chk("g3_mem_wdata", mem_wdata, 4'hC);
        tick(); req = 3'b010; req_rw = 3'b000; #1;
        chk("rel_gnt_held", gnt, 3'b001);
        tick();
        chk("gap0_gnt", gnt, 3'b000);
        chk("gap0_busy", busy, 1'b0);
        chk("gap0_mem_rw", mem_rw, 1'b0);
        tick();
        chk("idle0_gnt", gnt, 3'b000);

        // Port 1 reads rows 0..3 back to back.
        tick(); a_v[1] = 2'd0; #1;
        chk("p1_gnt", gnt, 3'b010);
        chk("p1_mem_addr", mem_addr, 2'd0);
        chk("p1_rvalid_c0", rvalid, 3'b000);
        tick(); a_v[1] = 2'd1; #1;
        chk("p1_rvalid_c1", rvalid, 3'b000);
        tick(); a_v[1] = 2'd2; #1;
        chk("p1_rvalid_c2", rvalid, 3'b010);
        chk("p1_rdata_r0", rdata, 4'h5);
        tick(); a_v[1] = 2'd3; #1;
        chk("p1_rvalid_c3", rvalid, 3'b010);
        chk("p1_rdata_r1", rdata, 4'hA);
        // Port 1 writes row 2 while port 2 tries to write row 3 without a grant.
        tick();
        req = 3'b110; req_rw = 3'b110; a_v[1] = 2'd2; w_v[1] = 4'h6; a_v[2] = 2'd3; w_v[2] = 4'hF; #1;
        chk("nonown_mem_rw", mem_rw, 1'b1);
        chk("nonown_mem_addr", mem_addr, 2'd2);
        chk("nonown_mem_wdata", mem_wdata, 4'h6);
        chk("p1_rvalid_c4", rvalid, 3'b010);
        chk("p1_rdata_r2", rdata, 4'h3);
        tick(); req = 3'b100; req_rw = 3'b100; #1;
        chk("p1_rvalid_c5", rvalid, 3'b010);
        chk("p1_rdata_r3", rdata, 4'hC);
        chk("p1_rel_mem_rw", mem_rw, 1'b0);
        tick();
        chk("gap1_rvalid", rvalid, 3'b000);
        chk("gap1_gnt", gnt, 3'b000);
        chk("gap1_mem_rw", mem_rw, 1'b0);
        tick();
        chk("idle1_mem_rw", mem_rw, 1'b0);
        chk("idle1_mem_addr", mem_addr, 2'd0);
        // Port 2 reads rows 3 and 2 back.
        tick(); req_rw = 3'b000; a_v[2] = 2'd3; #1;
        chk("p2_gnt", gnt, 3'b100);
        chk("p2_mem_addr", mem_addr, 2'd3);
        chk("p2_mem_rw", mem_rw, 1'b0);
        tick(); a_v[2] = 2'd2; #1;
        tick(); req = 3'b000; #1;
        chk("p2_rvalid_r3", rvalid, 3'b100);
        chk("row3_unchanged", rdata, 4'hC);
        tick();
        req = 3'b111; req_rw = 3'b111;
        for (int i = 0; i < 3; i++) begin a_v[i] = 2'd0; w_v[i] = 4'(i + 1); end
        #1;
        chk("gap2_rvalid", rvalid, 3'b100);
        chk("gap2_rdata_r2", rdata, 4'h6);
        chk("gap2_gnt", gnt, 3'b000);
        tick();
        chk("idle2_gnt", gnt, 3'b000);
        chk("idle2_mem_rw", mem_rw, 1'b0);
        tick();

        // All three request continuously; 5-cycle sessions rotate 0,1,2.
        for (int p = 0; p < 3; p++) begin
            oh = 3'b001 << p;
            for (int c = 0; c < 5; c++) begin
                #1;
                chk("rr_gnt", gnt, oh);
                chk("rr_mem_rw", mem_rw, 1'b1);
                chk("rr_mem_wdata", mem_wdata, p + 1);
                tick();
            end
            req[p] = 1'b0; req_rw[p] = 1'b0; #1;
            chk("rr_rel_gnt", gnt, oh);
            tick(); req[p] = 1'b1; req_rw[p] = 1'b1; #1;
            chk("rr_gap_gnt", gnt, 3'b000);
            chk("rr_gap_mem_rw", mem_rw, 1'b0);
            chk("rr_gap_busy", busy, 1'b0);
            tick();
            chk("rr_idle_gnt", gnt, 3'b000);
            chk("rr_idle_mem_rw", mem_rw, 1'b0);
            tick();
        end

        // Port 0 reads in its last owned cycle; the return is tagged to port 0.
        req = 3'b101; req_rw = 3'b100; a_v[0] = 2'd1; #1;
        chk("tag_gnt", gnt, 3'b001);
        chk("tag_mem_rw", mem_rw, 1'b0);
        chk("tag_mem_addr", mem_addr, 2'd1);
        tick(); req = 3'b100; req_rw = 3'b000; a_v[2] = 2'd0; #1;
        tick();
        chk("tag_gap_gnt", gnt, 3'b000);
        chk("tag_gap_rvalid", rvalid, 3'b001);
        chk("tag_gap_rdata", rdata, 4'hA);
        tick();
        chk("tag_idle_rvalid", rvalid, 3'b000);
        tick();
        chk("tag_p2_gnt", gnt, 3'b100);

        // Reset in the middle of port 2's read session.
        tick(); rst = 1'b1; #1;
        tick();
        chk("mrst_gnt", gnt, 3'b000);
        chk("mrst_rvalid", rvalid, 3'b000);
        chk("mrst_mem_rw", mem_rw, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", gnt, 3'b100);
        chk("post_rst_rvalid", rvalid, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mat_mem_arbiter.md
# mat_mem_arbiter

Session-based arbiter sharing the single-port matrix RAM of the ROLLO-I decrypt datapath between three requesters: the matrix loader (port 0), the Gauss-elimination controller (port 1) and the result unloader (port 2). A requester owns the RAM for a whole session (req high until release), so the elimination controller's cycle-exact address sequences and READ_DELAY-aligned systolic-array loading run unmodified. Read returns are tagged with the issuing port, so a handover never misroutes in-flight data.

## Interface
- k, 4: matrix rows (RAM depth); AW = CLOG2(k)
- l, 4: row width in bits
- READ_DELAY, 2: RAM read latency in cycles (≥1)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  3  per-port session request; held high for the whole session
- gnt  out  3  one-hot grant, registered
- req_addr  in  3*AW  port i at bits [i*AW +: AW]
- req_rw  in  3  per-port write enable (1 = write)
- req_wdata  in  3*l  port i at bits [i*l +: l]
- mem_addr  out  AW  RAM address
- mem_rw  out  1  RAM write enable
- mem_wdata  out  l  RAM write data
- mem_rdata  in  l  RAM read data
- rdata  out  l  read data to requesters (= mem_rdata)
- rvalid  out  3  one-hot: rdata belongs to port i this cycle
- busy  out  1  high while any port is granted

## Operation
- States: IDLE, OWN, GAP.
- IDLE: if any req, pick winner round-robin starting at port (last_owner+1) mod 3; register owner, set gnt[owner], go OWN. No req: stay.
- OWN: mem_addr/mem_rw/mem_wdata = combinational mux of owner's port (no added latency). Owner's req low at an edge: gnt cleared, last_owner updated, go GAP. Other ports' req ignored.
- GAP: one cycle, mem_rw = 0; then IDLE (re-arbitration in the same edge path: GAP → IDLE → grant = 2 cycles from release to next gnt).
- When not OWN: mem_rw = 0, mem_addr = 0, mem_wdata = 0.
- Read tagging: READ_DELAY-deep shift pipeline of {valid, id}; entry pushed each cycle with valid = (state==OWN & req[owner] & ~req_rw[owner]). rvalid[id] = valid at pipeline tail. Pipeline keeps shifting through GAP/IDLE.
- Requester must not drive RAM traffic before seeing gnt; port traffic without gnt has no effect.

## Timing
- Reset: state IDLE, gnt = 0, busy = 0, mem_rw = 0, mem_addr = 0, mem_wdata = 0, rvalid = 0, pipeline cleared, last_owner = 2 (so port 0 wins first).
- Grant latency: req rises at edge t → gnt high after edge t+1.
- Read issued by owner in cycle c → rvalid[owner] high in cycle c+READ_DELAY, exactly one cycle.
- Simultaneous requests: round-robin order only; ports that lose keep req high and are served later (no starvation: max wait two sessions).
- Owner drops req and re-raises next cycle: treated as new request, loses to any other pending port.
- Reads issued in last owned cycle return during GAP/next session with original tag.
- Reset mid-session: gnt drops next edge, in-flight rvalid suppressed.

## Structure
- Shared package/define file: NPORT = 3, port-id constants PORT_LOAD = 0, PORT_ELIM = 1, PORT_UNLOAD = 2, state encodings.
- One natural sub-module: rd_tag_pipe (READ_DELAY-deep {valid,id} shift register). Round-robin pick stays inline.

## Test plan
- Reset then req = 3'b011 → gnt = 3'b001 one cycle later; port 1 waits; after port 0 releases, gnt = 3'b010 two cycles after release.
- Port 1 owns, reads addr 0..3 back-to-back, READ_DELAY = 2 → rvalid = 3'b010 for 4 consecutive cycles starting 2 cycles after first read, rdata = RAM rows 0..3.
- All three req held continuously, each session 5 cycles → grant order 0,1,2,0,… with GAP cycle between sessions, mem_rw = 0 in every GAP.
- Port 0 reads in its final owned cycle, port 2 granted → rvalid = 3'b001 (not 3'b100) during GAP.
- Non-owner drives req_rw = 1, addr 3 while port 1 owns → mem_rw/mem_addr follow port 1 only; row 3 unchanged.
- rst asserted mid-session with reads in flight → next cycle gnt = 0, rvalid = 0, mem_rw = 0; after release req = 3'b100 → gnt = 3'b100.
